// File: rtl/sram_tester_pkg.sv
// rtl/sram_tester_pkg.sv - shared types, LFSR constants and step function for the SRAM tester
package sram_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  // Right-shifting Fibonacci register: feedback from bits 0,2,3,5 realises x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] next_lfsr(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/sram_pattern_gen.sv
// rtl/sram_pattern_gen.sv - test pattern source shared by write and read phases; SRAM_TESTER_LFSR_EN selects LFSR data
module sram_pattern_gen
  import sram_tester_pkg::*;
#(
  parameter int          ADDR_W = 18,
  parameter int          DATA_W = 16,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [DATA_W-1:0] pattern
);

`ifdef SRAM_TESTER_LFSR_EN
  logic [15:0]       lfsr;
  logic [ADDR_W-1:0] unused_base;

  assign unused_base = base;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= '0;
    end else if (restart) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= next_lfsr(lfsr);
    end
  end

  assign pattern = DATA_W'(lfsr);
`else
  logic [ADDR_W-1:0] addr;
  logic [15:0]       unused_seed;

  assign unused_seed = SEED;

  // Tracks the word address in step with the tester so data equals its own address
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (restart) begin
      addr <= base;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  assign pattern = DATA_W'(addr);
`endif

endmodule

// File: rtl/sram_amm_tester.sv
// rtl/sram_amm_tester.sv - Avalon-MM write/read-back memory tester; SRAM_TESTER_LFSR_EN selects LFSR pattern
module sram_amm_tester
  import sram_tester_pkg::*;
#(
  parameter int          ADDR_W  = 18,
  parameter int          DATA_W  = 16,
  parameter int          TIMEOUT = 64,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   words_i,
  output logic [ADDR_W-1:0] amm_address_o,
  output logic              amm_read_o,
  output logic              amm_write_o,
  output logic [DATA_W-1:0] amm_writedata_o,
  input  logic              amm_readdatavalid_i,
  input  logic [DATA_W-1:0] amm_readdata_i,
  input  logic              amm_waitrequest_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [15:0]       err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  // DONE adds one cycle ahead of done_o, so abort two short of TIMEOUT to land done_o TIMEOUT cycles after acceptance
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT - 2);

  state_t            state, next_state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [TW-1:0]     wait_cnt;
  logic              timeout_q;
  logic              wr_acc;
  logic              rd_acc;
  logic              last_word;
  logic              gen_restart;
  logic              gen_advance;
  logic              mismatch;
  logic              to_hit;
  logic [ADDR_W-1:0] gen_base;
  logic [DATA_W-1:0] pattern;

  assign idx_inc   = idx + (ADDR_W + 1)'(1);
  assign last_word = (idx_inc == words_q);
  assign wr_acc    = amm_write_o && !amm_waitrequest_i;
  assign rd_acc    = amm_read_o && !amm_waitrequest_i;
  assign gen_base  = (state == IDLE) ? base_addr_i : base_q;

  sram_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .clk     (clk_i),
    .rst     (rst_i),
    .restart (gen_restart),
    .advance (gen_advance),
    .base    (gen_base),
    .pattern (pattern)
  );

  assign amm_writedata_o = pattern;

  always_comb begin
    next_state  = state;
    gen_restart = 1'b0;
    gen_advance = 1'b0;
    mismatch    = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE: begin
        // busy_o still covers the done_o cycle, so a start there is dropped
        if (start_i && !busy_o) begin
          gen_restart = 1'b1;
          next_state  = (words_i == '0) ? DONE : WR;
        end
      end
      WR: begin
        if (wr_acc) begin
          if (last_word) begin
            gen_restart = 1'b1;
            next_state  = RD_REQ;
          end else begin
            gen_advance = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (rd_acc) begin
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (amm_readdatavalid_i) begin
          mismatch    = (amm_readdata_i != pattern);
          gen_advance = 1'b1;
          next_state  = last_word ? DONE : RD_REQ;
        end else if (wait_cnt >= TO_LIMIT) begin
          to_hit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      base_q           <= '0;
      words_q          <= '0;
      idx              <= '0;
      wait_cnt         <= '0;
      timeout_q        <= 1'b0;
      amm_address_o    <= '0;
      amm_read_o       <= 1'b0;
      amm_write_o      <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      timeout_o        <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      state       <= next_state;
      amm_write_o <= (next_state == WR);
      amm_read_o  <= (next_state == RD_REQ);
      busy_o      <= (next_state != IDLE) || (state == DONE);
      done_o      <= (state == DONE);
      case (state)
        IDLE: begin
          if (gen_restart) begin
            base_q           <= base_addr_i;
            words_q          <= words_i;
            idx              <= '0;
            amm_address_o    <= base_addr_i;
            timeout_q        <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
          end
        end
        WR: begin
          if (wr_acc) begin
            if (last_word) begin
              idx           <= '0;
              amm_address_o <= base_q;
            end else begin
              idx           <= idx_inc;
              amm_address_o <= amm_address_o + ADDR_W'(1);
            end
          end
        end
        RD_REQ: begin
          if (rd_acc) begin
            wait_cnt <= '0;
          end
        end
        RD_WAIT: begin
          if (amm_readdatavalid_i) begin
            if (mismatch) begin
              if (err_cnt_o != 16'hFFFF) begin
                err_cnt_o <= err_cnt_o + 16'd1;
              end
              if (err_cnt_o == '0) begin
                first_err_addr_o <= amm_address_o;
              end
            end
            idx           <= idx_inc;
            amm_address_o <= amm_address_o + ADDR_W'(1);
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
            if (to_hit) begin
              timeout_q <= 1'b1;
            end
          end
        end
        DONE: begin
          pass_o    <= (err_cnt_o == '0) && !timeout_q;
          timeout_o <= timeout_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_amm_tester.sv
// tb/tb_sram_amm_tester.sv - directed bench for sram_amm_tester with an Avalon-MM slave stub
module tb_sram_amm_tester;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [17:0]       base = '0;
  logic [18:0]       words = '0;
  logic [17:0]       amm_address;
  logic              amm_read;
  logic              amm_write;
  logic [15:0]       amm_writedata;
  logic              amm_readdatavalid = 1'b0;
  logic [15:0]       amm_readdata = '0;
  logic              amm_waitrequest = 1'b0;
  logic              busy, done, pass, timeout;
  logic [15:0]       err_cnt;
  logic [17:0]       first_err_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sram_amm_tester #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .SEED    (16'hACE1)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .base_addr_i         (base),
    .words_i             (words),
    .amm_address_o       (amm_address),
    .amm_read_o          (amm_read),
    .amm_write_o         (amm_write),
    .amm_writedata_o     (amm_writedata),
    .amm_readdatavalid_i (amm_readdatavalid),
    .amm_readdata_i      (amm_readdata),
    .amm_waitrequest_i   (amm_waitrequest),
    .busy_o              (busy),
    .done_o              (done),
    .pass_o              (pass),
    .timeout_o           (timeout),
    .err_cnt_o           (err_cnt),
    .first_err_addr_o    (first_err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // slave stub configuration and bookkeeping
  int          stall_cfg = 0;
  int          lat_cfg   = 1;
  bit          no_valid  = 0;
  int          flip_a    = -1;
  int          flip_b    = -1;
  logic [15:0] mem [bit [17:0]];
  int          wr_cnt, rd_cnt, stable_err, wr_hi, req_hi, rd_acc_cyc;
  logic [17:0] wr_log[$];
  logic [17:0] rd_log[$];
  bit          in_req, req_go, cap_wr, rd_pend;
  logic [17:0] cap_addr;
  logic [15:0] cap_data, rd_data;
  int          stall_left, rd_lat;

  always @(negedge clk) begin
    if (rst) begin
      mem.delete();
      wr_log.delete();
      rd_log.delete();
      wr_cnt = 0; rd_cnt = 0; stable_err = 0; wr_hi = 0; req_hi = 0; rd_acc_cyc = 0;
      in_req = 0; req_go = 0; rd_pend = 0; stall_left = 0; rd_lat = 0;
      amm_waitrequest = 1'b0;
      amm_readdatavalid = 1'b0;
    end else begin
      if (req_go) begin
        if (cap_wr) begin
          mem[cap_addr] = cap_data;
          wr_cnt++;
          wr_log.push_back(cap_addr);
        end else begin
          rd_cnt++;
          rd_log.push_back(cap_addr);
          rd_acc_cyc = cyc;
          if (!no_valid) begin
            rd_pend = 1;
            rd_lat  = lat_cfg;
            rd_data = mem.exists(cap_addr) ? mem[cap_addr] : 16'h0000;
            if (int'(cap_addr) == flip_a || int'(cap_addr) == flip_b) rd_data[0] = ~rd_data[0];
          end
        end
        req_go = 0;
        in_req = 0;
      end
      amm_readdatavalid = 1'b0;
      if (rd_pend) begin
        if (rd_lat <= 1) begin
          amm_readdatavalid = 1'b1;
          amm_readdata = rd_data;
          rd_pend = 0;
        end else begin
          rd_lat--;
        end
      end
      if (amm_write || amm_read) begin
        req_hi++;
        if (amm_write) wr_hi++;
        if (!in_req) begin
          in_req = 1; stall_left = stall_cfg;
          cap_wr = amm_write; cap_addr = amm_address; cap_data = amm_writedata;
        end else if (amm_address !== cap_addr || amm_write !== cap_wr || (cap_wr && amm_writedata !== cap_data)) begin
          stable_err++;
        end
        if (stall_left > 0) begin
          amm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          amm_waitrequest = 1'b0;
          req_go = 1;
        end
      end else begin
        amm_waitrequest = 1'b0;
      end
    end
  end

  function automatic logic [15:0] exp_pat(input logic [17:0] a, input int i);
    logic [15:0] l;
`ifdef SRAM_TESTER_LFSR_EN
    l = 16'hACE1;
    for (int k = 0; k < i; k++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
`else
    l = a[15:0];
`endif
    return l;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic stub_cfg(input int stall, input bit nv, input int fa, input int fb);
    stall_cfg = stall; lat_cfg = 1; no_valid = nv; flip_a = fa; flip_b = fb;
  endtask

  task automatic pulse_start(input logic [17:0] b, input logic [18:0] w);
    @(negedge clk);
    base = b; words = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin got = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_pass_timeout: got %b%b want 00", pass, timeout); end
    n_checks++; if (err_cnt !== 16'h0 || first_err_addr !== 18'h0) begin n_fail++; $display("FAIL reset_err: got %h/%h want 0/0", err_cnt, first_err_addr); end
    n_checks++; if (amm_write !== 1'b0 || amm_read !== 1'b0 || amm_address !== 18'h0 || amm_writedata !== 16'h0) begin
      n_fail++; $display("FAIL reset_amm: got w%b r%b a%h d%h want all 0", amm_write, amm_read, amm_address, amm_writedata);
    end
  endtask

  task automatic test_basic();
    bit got;
    int bad;
    stub_cfg(0, 0, -1, -1);
    do_reset();
    pulse_start(18'h0, 19'd16);
    n_checks++; if (amm_write !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_first_write: got w%b busy%b want 1 1", amm_write, busy); end
    wait_done(got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL basic_done: got no done want done"); end
    n_checks++; if (pass !== 1'b1 || err_cnt !== 16'h0 || timeout !== 1'b0) begin n_fail++; $display("FAIL basic_result: got p%b e%h t%b want 1 0 0", pass, err_cnt, timeout); end
    n_checks++; if (wr_cnt != 16 || rd_cnt != 16) begin n_fail++; $display("FAIL basic_counts: got wr%0d rd%0d want 16 16", wr_cnt, rd_cnt); end
    n_checks++; if (wr_hi != 16) begin n_fail++; $display("FAIL basic_wr_cycles: got %0d want 16", wr_hi); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      logic [17:0] a;
      a = 18'(i);
      if (!mem.exists(a) || mem[a] !== exp_pat(a, i)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_mem: got %0d bad words want 0", bad); end
  endtask

  task automatic test_stall();
    bit got;
    stub_cfg(3, 0, -1, -1);
    do_reset();
    pulse_start(18'h100, 19'd16);
    wait_done(got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL stall_done: got no done want done"); end
    n_checks++; if (wr_cnt != 16 || rd_cnt != 16) begin n_fail++; $display("FAIL stall_counts: got wr%0d rd%0d want 16 16", wr_cnt, rd_cnt); end
    n_checks++; if (stable_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stable_err); end
    n_checks++; if (wr_hi != 64) begin n_fail++; $display("FAIL stall_wr_cycles: got %0d want 64", wr_hi); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL stall_pass: got %b want 1", pass); end
  endtask

  task automatic test_errors();
    bit got;
    stub_cfg(0, 0, 5, 9);
    do_reset();
    pulse_start(18'h0, 19'd16);
    wait_done(got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL err_done: got no done want done"); end
    n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL err_count: got %0d want 2", err_cnt); end
    n_checks++; if (first_err_addr !== 18'd5) begin n_fail++; $display("FAIL err_first: got %h want 5", first_err_addr); end
    n_checks++; if (pass !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL err_pass: got p%b t%b want 0 0", pass, timeout); end
  endtask

  task automatic test_zero_words();
    stub_cfg(0, 0, -1, -1);
    do_reset();
    pulse_start(18'h55, 19'd0);
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_c1: got d%b b%b want 0 1", done, busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("FAIL zero_c2: got d%b p%b want 1 1", done, pass); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_c3: got d%b b%b want 0 0", done, busy); end
    n_checks++; if (req_hi != 0) begin n_fail++; $display("FAIL zero_requests: got %0d want 0", req_hi); end
  endtask

  task automatic test_wrap();
    bit got;
    int bad;
    logic [17:0] exp_a [4];
    exp_a = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    stub_cfg(0, 0, -1, -1);
    do_reset();
    pulse_start(18'h3FFFE, 19'd4);
    wait_done(got);
    n_checks++; if (!got || wr_log.size() != 4 || rd_log.size() != 4) begin
      n_fail++; $display("FAIL wrap_sizes: got done%b wr%0d rd%0d want 1 4 4", got, wr_log.size(), rd_log.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (wr_log[i] !== exp_a[i] || rd_log[i] !== exp_a[i]) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_addrs: got %0d bad addresses want 0", bad); end
    end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL wrap_pass: got %b want 1", pass); end
  endtask

  task automatic test_timeout();
    bit got;
    stub_cfg(0, 1, -1, -1);
    do_reset();
    pulse_start(18'h0, 19'd4);
    wait_done(got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL to_done: got no done want done"); end
    n_checks++; if (timeout !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL to_flags: got t%b p%b want 1 0", timeout, pass); end
    n_checks++; if (cyc - rd_acc_cyc != TIMEOUT) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", cyc - rd_acc_cyc, TIMEOUT); end
    n_checks++; if (rd_cnt != 1) begin n_fail++; $display("FAIL to_reads: got %0d want 1", rd_cnt); end
  endtask

  task automatic test_reset_mid();
    bit got;
    stub_cfg(0, 0, -1, -1);
    do_reset();
    pulse_start(18'h0, 19'd16);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (amm_write !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got w%b b%b want 0 0", amm_write, busy); end
    do_reset();
    pulse_start(18'h0, 19'd16);
    wait_done(got);
    n_checks++; if (!got || pass !== 1'b1 || wr_cnt != 16) begin n_fail++; $display("FAIL mid_restart: got d%b p%b wr%0d want 1 1 16", got, pass, wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_errors();
    test_zero_words();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
